// File: rtl/ppu_arbiter.sv
// Round-robin arbiter sharing one combinational ppu between two requesters.
// Latency: accept edge to resp_valid is 2 edges; best-case issue interval is 3 cycles.
// Backpressure: resp_ready low holds RESP with the result stable; both req*_ready stay low until IDLE.
module ppu_arbiter #(
    parameter int N  = 32,
    parameter int es = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_in1,
    input  logic [N-1:0] req0_in2,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_in1,
    input  logic [N-1:0] req1_in2,
    output logic [N-1:0] ppu_in1,
    output logic [N-1:0] ppu_in2,
    input  logic [N-1:0] ppu_out,
    input  logic         ppu_inf,
    input  logic         ppu_zero,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_out,
    output logic         resp_inf,
    output logic         resp_zero,
    output logic         resp_id,
    output logic         busy
);

    // es only configures the external ppu; it is carried here so both share one parameter set.
    localparam int es_unused = es;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         last_grant;
    logic         gnt;
    logic         accept;
    logic         id_q;
    logic [N-1:0] op1_q;
    logic [N-1:0] op2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        gnt        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    // Gated by rst_n so no handshake is offered while reset is held.
                    req0_ready = rst_n && !gnt;
                    req1_ready = rst_n && gnt;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            resp_out   <= '0;
            resp_inf   <= 1'b0;
            resp_zero  <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= gnt;
                id_q       <= gnt;
                op1_q      <= gnt ? req1_in1 : req0_in1;
                op2_q      <= gnt ? req1_in2 : req0_in2;
            end
            // The ppu has had the whole EXEC cycle to settle on the held operands.
            if (state == EXEC) begin
                resp_out  <= ppu_out;
                resp_inf  <= ppu_inf;
                resp_zero <= ppu_zero;
            end
        end
    end

    assign ppu_in1 = op1_q;
    assign ppu_in2 = op2_q;
    assign resp_id = id_q;

endmodule

// File: doc/ppu_arbiter.md
PPU_ARBITER -- requirements
Module: ppu_arbiter

Interface
REQ-001 Parameter N, default 32, posit word width in bits.
REQ-002 Parameter es, default 2, posit exponent field width, passed unchanged to the shared ppu instance.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 has an operand pair.
REQ-006 req0_ready  output  1  arbiter accepts requester 0 this cycle.
REQ-007 req0_in1, req0_in2  input  N each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_in1, req1_in2 -- same widths and meaning as REQ-005..007, for requester 1.
REQ-009 ppu_in1, ppu_in2  output  N each  operands driven to the shared combinational ppu.
REQ-010 ppu_out  input  N  ppu result.
REQ-011 ppu_inf, ppu_zero  input  1 each  ppu result flags.
REQ-012 resp_valid  output  1  result available.
REQ-013 resp_ready  input  1  consumer accepts result.
REQ-014 resp_out  output  N  latched result.
REQ-015 resp_inf, resp_zero  output  1 each  latched flags.
REQ-016 resp_id  output  1  index of the requester that owns the result.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, EXEC and RESP.
REQ-019 IDLE: if any req*_valid, the granted requester's ready SHALL be high combinationally, and on the edge the operands and id SHALL latch and the FSM SHALL go to EXEC.
REQ-020 At most one req*_ready SHALL be high in any cycle, and both SHALL be low outside IDLE.
REQ-021 Arbitration SHALL be round-robin with a 1-bit last_grant register.
- When both requesters are valid, grant the one not equal to last_grant.
- When only one is valid, grant it.
- last_grant updates on every accept.
REQ-022 ppu_in1/ppu_in2 SHALL be driven continuously from the operand registers so the ppu inputs stay stable through EXEC.
REQ-023 EXEC SHALL last exactly one cycle. On its closing edge, ppu_out, ppu_inf and ppu_zero SHALL be captured into resp_out, resp_inf and resp_zero, and the FSM SHALL go to RESP.
REQ-024 RESP: resp_valid SHALL be high. resp_out, resp_inf, resp_zero and resp_id SHALL hold stable until the edge where resp_ready is high, and on that edge the FSM SHALL return to IDLE.
REQ-025 Latency from the accept edge to resp_valid high SHALL be 2 edges. Minimum issue interval SHALL be 3 cycles with resp_ready tied high.
REQ-026 A requester's valid dropping while it is not granted SHALL have no effect; it SHALL NOT be lost or recorded.
REQ-027 resp_ready high outside RESP SHALL be ignored.
REQ-028 A new request arriving on the same edge a response completes SHALL NOT be accepted until the following IDLE cycle, because ready is combinational from IDLE only.
REQ-029 No arithmetic SHALL occur in this block; result bits pass through unmodified at width N.

Reset
REQ-030 While rst_n is low, the block SHALL be held in this state:
- state = IDLE;
- last_grant = 1, so requester 0 wins the first contention;
- operand registers, resp_out, resp_inf, resp_zero and resp_id = 0;
- resp_valid, busy, req0_ready and req1_ready = 0.
REQ-031 Assertion of rst_n in EXEC or RESP SHALL abandon the transaction immediately. No response SHALL be produced after release.
REQ-032 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-033 Single request: req0 with in1=0x40000000 and in2=0x40000000, resp_ready=1 -> req0_ready high in cycle 0, resp_valid high after 2 edges, resp_id=0, resp_out equals the ppu output for those operands.
REQ-034 Contention from reset: both requesters valid continuously, resp_ready=1 -> grants alternate 0,1,0,1, and resp_id follows the same sequence.
REQ-035 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid stays high, resp_out stays stable, both readies stay 0; the FSM leaves RESP on the first resp_ready=1 edge.
REQ-036 Operand stability: req1 operands change while the FSM is in EXEC or RESP -> ppu_in1/ppu_in2 and resp_out are unchanged.
REQ-037 Reset mid-operation: rst_n pulled low during EXEC -> all outputs 0 asynchronously; after release, no resp_valid without a new request.
REQ-038 Regression: the 256 operand pairs from Pin1_32bit.txt and Pin2_32bit.txt, split across both requesters -> every response matches Pout_32bit_ES2.txt for its operand pair, with the correct resp_id.
